// File: rtl/flexemg_sched_pkg.sv
// rtl/flexemg_sched_pkg.sv - shared state encoding, debug field width and defaults for frame_scheduler
package flexemg_sched_pkg;

    localparam int STATE_W         = 4;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_ARM      = 4'd1,
        ST_WAIT_RDY = 4'd2,
        ST_PACK     = 4'd3
    } sched_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - conversion-start / frame-ready / packetiser handshake bundle
interface frame_scheduler_if;

    logic frame_req_n0;
    logic frame_req_n1;
    logic acc_sample_req;
    logic adc_frame_rdy_n0;
    logic adc_frame_rdy_n1;
    logic pdma_en;
    logic pdma_done_irq_req;

    modport master (
        output frame_req_n0, frame_req_n1, acc_sample_req, pdma_en,
        input  adc_frame_rdy_n0, adc_frame_rdy_n1, pdma_done_irq_req
    );

    modport slave (
        input  frame_req_n0, frame_req_n1, acc_sample_req, pdma_en,
        output adc_frame_rdy_n0, adc_frame_rdy_n1, pdma_done_irq_req
    );

endinterface

// File: rtl/period_timer.sv
// rtl/period_timer.sv - free-running frame period counter producing a one-cycle tick
module period_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;

    // >= rather than == so a period shrunk below the running count still ticks promptly
    assign tick = en && (period != '0) && (cnt >= period);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (!en || tick || (period == '0)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - periodic ADC/accelerometer acquisition and packet scheduler; FRAME_SCHED_WDT_EN adds a WAIT_RDY watchdog
module frame_scheduler
    import flexemg_sched_pkg::*;
#(
    parameter int PERIOD_W       = 16,
    parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC,
    parameter int DEBUG_BUS_SIZE = 4
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      sched_en,
    input  logic [PERIOD_W-1:0]       period,
    frame_scheduler_if.master         bus,
    output logic [15:0]               frame_cnt,
    output logic [7:0]                overrun_cnt,
    output logic [7:0]                timeout_cnt,
    output logic                      busy,
    output logic [DEBUG_BUS_SIZE-1:0] debug
);

    sched_state_t state, nxt;
    logic tick;
    logic lat0, lat1;
    logic rdy0_seen, rdy1_seen, both_rdy;
    logic timeout;
    logic frame_inc, overrun_inc, timeout_inc;

    period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rstb   (rstb),
        .en     (sched_en),
        .period (period),
        .tick   (tick)
    );

    // a pulse arriving in the same cycle counts as latched, so PACK follows the last ready by one cycle
    assign rdy0_seen = lat0 | bus.adc_frame_rdy_n0;
    assign rdy1_seen = lat1 | bus.adc_frame_rdy_n1;
    assign both_rdy  = rdy0_seen & rdy1_seen;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lat0 <= 1'b0;
            lat1 <= 1'b0;
        end else if (state == ST_WAIT_RDY) begin
            lat0 <= rdy0_seen;
            lat1 <= rdy1_seen;
        end else begin
            lat0 <= 1'b0;
            lat1 <= 1'b0;
        end
    end

`ifdef FRAME_SCHED_WDT_EN
    localparam int WDT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WDT_W-1:0] wdt_cnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wdt_cnt <= '0;
        end else if (state == ST_WAIT_RDY) begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end else begin
            wdt_cnt <= '0;
        end
    end

    assign timeout = (state == ST_WAIT_RDY) && (wdt_cnt == WDT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            timeout_cnt <= '0;
        end else if (timeout_inc) begin
            timeout_cnt <= sat_inc8(timeout_cnt);
        end
    end
`else
    assign timeout     = 1'b0;
    assign timeout_cnt = '0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt                = state;
        frame_inc          = 1'b0;
        overrun_inc        = 1'b0;
        timeout_inc        = 1'b0;
        bus.frame_req_n0   = 1'b0;
        bus.frame_req_n1   = 1'b0;
        bus.acc_sample_req = 1'b0;
        bus.pdma_en        = 1'b0;
        busy               = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (tick) nxt = ST_ARM;
            end
            ST_ARM: begin
                bus.frame_req_n0   = 1'b1;
                bus.frame_req_n1   = 1'b1;
                bus.acc_sample_req = 1'b1;
                overrun_inc        = tick;
                nxt                = sched_en ? ST_WAIT_RDY : ST_IDLE;
            end
            ST_WAIT_RDY: begin
                overrun_inc = tick;
                if (!sched_en) begin
                    nxt = ST_IDLE;
                end else if (both_rdy) begin
                    nxt = ST_PACK;
                end else if (timeout) begin
                    nxt         = ST_IDLE;
                    timeout_inc = 1'b1;
                end
            end
            ST_PACK: begin
                bus.pdma_en = 1'b1;
                // a tick landing on the completion cycle starts the next frame rather than being dropped
                if (bus.pdma_done_irq_req) begin
                    frame_inc = 1'b1;
                    nxt       = tick ? ST_ARM : ST_IDLE;
                end else begin
                    overrun_inc = tick;
                end
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            if (frame_inc)   frame_cnt   <= frame_cnt + 16'd1;
            if (overrun_inc) overrun_cnt <= sat_inc8(overrun_cnt);
        end
    end

    generate
        if (DEBUG_BUS_SIZE > STATE_W) begin : g_dbg_wide
            assign debug = {{(DEBUG_BUS_SIZE-STATE_W){1'b0}}, state};
        end else begin : g_dbg_narrow
            assign debug = state[DEBUG_BUS_SIZE-1:0];
        end
    endgenerate

endmodule
